// File: rtl/line_buffer_read_port.sv
// Read-side responder for one cache refill line: fills word-by-word from the refill
// channel and answers {id, offset} word reads through a registered response slot.
module line_buffer_read_port #(
    parameter int DATA_W = 64,
    parameter int WORDS  = 4,
    parameter int ID_W   = 2,
    parameter int OFF_W  = $clog2(WORDS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              io_refill_start,
    input  logic              io_refill_valid,
    output logic              io_refill_ready,
    input  logic [DATA_W-1:0] io_refill_data,
    input  logic              io_invalidate,
    input  logic              io_req_valid,
    output logic              io_req_ready,
    input  logic [ID_W-1:0]   io_req_id,
    input  logic [OFF_W-1:0]  io_req_offset,
    output logic              io_resp_valid,
    input  logic              io_resp_ready,
    output logic [ID_W-1:0]   io_resp_id,
    output logic [DATA_W-1:0] io_resp_data,
    output logic [1:0]        io_state,
    output logic [WORDS-1:0]  io_word_valid
);

    // state | meaning
    // EMPTY   | no line held, nothing readable
    // FILLING | refill in progress, arrived words readable
    // FULL    | every word arrived
    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    logic [1:0]        r_state;
    logic [OFF_W-1:0]  r_cnt;
    logic [WORDS-1:0]  r_word_valid;
    logic [DATA_W-1:0] r_mem [WORDS];
    logic              r_resp_valid;
    logic [ID_W-1:0]   r_resp_id;
    logic [DATA_W-1:0] r_resp_data;

    logic w_refill_ready;
    logic w_beat;
    logic w_req_ready;
    logic w_req_acc;

    assign w_refill_ready = (r_state == ST_FILLING) & ~io_invalidate & ~io_refill_start;
    assign w_beat         = io_refill_valid & w_refill_ready;
    // No write-to-read bypass: only words flagged before this edge are servable.
    assign w_req_ready    = (r_state != ST_EMPTY) & r_word_valid[io_req_offset]
                          & (~r_resp_valid | io_resp_ready)
                          & ~io_invalidate & ~io_refill_start;
    assign w_req_acc      = io_req_valid & w_req_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_EMPTY;
            r_cnt        <= '0;
            r_word_valid <= '0;
        end else if (io_invalidate) begin
            r_state      <= ST_EMPTY;
            r_cnt        <= '0;
            r_word_valid <= '0;
        end else if (io_refill_start) begin
            r_state      <= ST_FILLING;
            r_cnt        <= '0;
            r_word_valid <= '0;
        end else if (w_beat) begin
            r_word_valid[r_cnt] <= 1'b1;
            r_cnt               <= r_cnt + OFF_W'(1);
            if (r_cnt == OFF_W'(WORDS - 1)) begin
                r_state <= ST_FULL;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_beat) begin
            r_mem[r_cnt] <= io_refill_data;
        end
    end

    // The response slot is independent of the line state so invalidate/restart never corrupt it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_data  <= '0;
        end else if (w_req_acc) begin
            r_resp_valid <= 1'b1;
            r_resp_id    <= io_req_id;
            r_resp_data  <= r_mem[io_req_offset];
        end else if (io_resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign io_refill_ready = w_refill_ready;
    assign io_req_ready    = w_req_ready;
    assign io_resp_valid   = r_resp_valid;
    assign io_resp_id      = r_resp_id;
    assign io_resp_data    = r_resp_data;
    assign io_state        = r_state;
    assign io_word_valid   = r_word_valid;

endmodule

// File: tb/tb_line_buffer_read_port.sv
// Directed plus randomized bench for line_buffer_read_port, checked against an
// array/queue reference of the line and response slot.
module tb_line_buffer_read_port;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        io_refill_start, io_refill_valid, io_refill_ready;
    logic [63:0] io_refill_data;
    logic        io_invalidate;
    logic        io_req_valid, io_req_ready;
    logic [1:0]  io_req_id, io_req_offset;
    logic        io_resp_valid, io_resp_ready;
    logic [1:0]  io_resp_id;
    logic [63:0] io_resp_data;
    logic [1:0]  io_state;
    logic [3:0]  io_word_valid;

    int checks = 0;
    int errors = 0;

    line_buffer_read_port dut (
        .clock(clock), .reset_n(reset_n),
        .io_refill_start(io_refill_start), .io_refill_valid(io_refill_valid),
        .io_refill_ready(io_refill_ready), .io_refill_data(io_refill_data),
        .io_invalidate(io_invalidate),
        .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
        .io_req_id(io_req_id), .io_req_offset(io_req_offset),
        .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
        .io_resp_id(io_resp_id), .io_resp_data(io_resp_data),
        .io_state(io_state), .io_word_valid(io_word_valid)
    );

    always #5 clock = ~clock;

    // Reference: line contents, arrival flags, fill position, and the response slot.
    int          m_state;
    int          m_cnt;
    logic [63:0] m_mem [4];
    bit          m_wv [4];
    bit          m_rv;
    int          m_rid;
    logic [63:0] m_rdata;
    bit          last_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_rv = 0; m_rid = 0; m_rdata = '0;
        for (int i = 0; i < 4; i++) m_wv[i] = 0;
    endtask

    function automatic logic [3:0] m_wv_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_wv[i];
        return v;
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, ".state"}, 64'(io_state), 64'(m_state));
        chk({tag, ".wv"}, 64'(io_word_valid), 64'(m_wv_vec()));
        chk({tag, ".rvalid"}, 64'(io_resp_valid), 64'(m_rv));
        chk({tag, ".rid"}, 64'(io_resp_id), 64'(m_rid));
        chk({tag, ".rdata"}, io_resp_data, m_rdata);
    endtask

    task automatic step(input bit st, input bit inv, input bit rv, input logic [63:0] rd,
                        input bit qv, input int qid, input int qoff, input bit rr);
        bit exp_fr, exp_qr, beat;
        @(negedge clock);
        io_refill_start = st; io_invalidate = inv; io_refill_valid = rv;
        io_refill_data = rd; io_req_valid = qv; io_req_id = 2'(qid);
        io_req_offset = 2'(qoff); io_resp_ready = rr;
        #1;
        exp_fr = (m_state == 1) && !inv && !st;
        exp_qr = (m_state != 0) && m_wv[qoff] && (!m_rv || rr) && !inv && !st;
        chk("refill_ready", 64'(io_refill_ready), 64'(exp_fr));
        chk("req_ready", 64'(io_req_ready), 64'(exp_qr));
        beat = rv && exp_fr;
        last_acc = qv && exp_qr;
        if (last_acc) begin
            m_rv = 1; m_rid = qid; m_rdata = m_mem[qoff];
        end else if (rr) begin
            m_rv = 0;
        end
        if (inv || st) begin
            m_state = inv ? 0 : 1; m_cnt = 0;
            for (int i = 0; i < 4; i++) m_wv[i] = 0;
        end else if (beat) begin
            m_mem[m_cnt] = rd; m_wv[m_cnt] = 1;
            if (m_cnt == 3) begin m_state = 2; m_cnt = 0; end
            else m_cnt++;
        end
        @(posedge clock);
        #1;
        check_regs("cyc");
    endtask

    task automatic idle(input bit rr);
        step(0, 0, 0, '0, 0, 0, 0, rr);
    endtask

    task automatic beat(input logic [63:0] d);
        step(0, 0, 1, d, 0, 0, 0, 1);
    endtask

    initial begin
        bit [3:0] pend;
        int n;
        reset_n = 0;
        io_refill_start = 0; io_invalidate = 0; io_refill_valid = 0; io_refill_data = '0;
        io_req_valid = 0; io_req_id = 0; io_req_offset = 0; io_resp_ready = 1;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("rst.state", 64'(io_state), 0);
        chk("rst.wv", 64'(io_word_valid), 0);
        chk("rst.rvalid", 64'(io_resp_valid), 0);
        chk("rst.rid", 64'(io_resp_id), 0);
        chk("rst.rdata", io_resp_data, 0);
        chk("rst.refill_ready", 64'(io_refill_ready), 0);
        chk("rst.req_ready", 64'(io_req_ready), 0);
        @(negedge clock);
        reset_n = 1;

        // Full fill then a read of the last word.
        step(1, 0, 0, '0, 0, 0, 0, 1);
        chk("fill.state1", 64'(io_state), 1);
        for (int k = 0; k < 4; k++) beat(64'hA0 + 64'(k));
        chk("fill.state2", 64'(io_state), 2);
        step(0, 0, 0, '0, 1, 2, 3, 1);
        chk("rd3.valid", 64'(io_resp_valid), 1);
        chk("rd3.id", 64'(io_resp_id), 2);
        chk("rd3.data", io_resp_data, 64'hA3);

        // Hit-under-fill.
        step(1, 0, 0, '0, 0, 0, 0, 1);
        beat(64'hA0);
        beat(64'hA1);
        step(0, 0, 0, '0, 1, 0, 1, 1);
        chk("huf.data1", io_resp_data, 64'hA1);
        step(0, 0, 1, 64'hA2, 1, 0, 2, 1);
        chk("huf.off2_blocked", 64'(last_acc), 0);
        step(0, 0, 0, '0, 1, 0, 2, 1);
        chk("huf.off2_ok", 64'(last_acc), 1);
        chk("huf.data2", io_resp_data, 64'hA2);
        beat(64'hA3);

        // Backpressure with a queued request released in the same cycle.
        step(0, 0, 0, '0, 1, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, '0, 1, 3, 2, 0);
            chk("bp.data_held", io_resp_data, 64'hA0);
            chk("bp.id_held", 64'(io_resp_id), 1);
        end
        step(0, 0, 0, '0, 1, 3, 2, 1);
        chk("bp.rel_valid", 64'(io_resp_valid), 1);
        chk("bp.rel_data", io_resp_data, 64'hA2);
        idle(1);

        // Invalidate mid-fill with a held response.
        step(1, 0, 0, '0, 0, 0, 0, 1);
        beat(64'hA0);
        step(0, 0, 1, 64'hA1, 1, 3, 0, 0);
        step(0, 1, 1, 64'h55, 0, 0, 0, 0);
        chk("inv.state", 64'(io_state), 0);
        chk("inv.wv", 64'(io_word_valid), 0);
        idle(0);
        chk("inv.rid", 64'(io_resp_id), 3);
        chk("inv.rdata", io_resp_data, 64'hA0);
        idle(1);
        chk("inv.drained", 64'(io_resp_valid), 0);

        // Start+invalidate collision, restart mid-fill, stale-data check.
        step(1, 0, 0, '0, 0, 0, 0, 1);
        step(1, 1, 0, '0, 0, 0, 0, 1);
        chk("coll.state", 64'(io_state), 0);
        step(1, 0, 0, '0, 0, 0, 0, 1);
        beat(64'hC0);
        beat(64'hC1);
        step(1, 0, 0, '0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) beat(64'hB0 + 64'(k));
        chk("restart.full", 64'(io_state), 2);
        step(0, 0, 0, '0, 1, 0, 0, 1);
        chk("restart.data0", io_resp_data, 64'hB0);

        // Four arbiter clients, fixed priority (lowest id wins).
        pend = 4'hF; n = 0;
        while (pend != 0 && n < 10) begin
            int w;
            w = 0;
            while (!pend[w]) w++;
            step(0, 0, 0, '0, 1, w, w, 1);
            n++;
            if (last_acc) begin
                pend[w] = 0;
                chk("arb.id", 64'(io_resp_id), 64'(w));
                chk("arb.data", io_resp_data, 64'hB0 + 64'(w));
            end
        end
        chk("arb.cycles", 64'(n), 4);
        idle(1);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 3) != 0, {$urandom, $urandom},
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
        end

        // Reset in the middle of a held response drops it immediately.
        step(1, 0, 0, '0, 0, 0, 0, 1);
        beat(64'hD0);
        step(0, 0, 0, '0, 1, 1, 0, 0);
        chk("mrst.pending", 64'(io_resp_valid), 1);
        @(negedge clock);
        #2 reset_n = 0;
        #1;
        model_reset();
        chk("mrst.rvalid", 64'(io_resp_valid), 0);
        chk("mrst.state", 64'(io_state), 0);
        chk("mrst.wv", 64'(io_word_valid), 0);
        chk("mrst.rdata", io_resp_data, 0);
        @(negedge clock);
        reset_n = 1;
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/line_buffer_read_port.md
# line_buffer_read_port

Read-side responder for the cache line buffer. It owns one refill line of `WORDS` data words, written beat by beat from the memory refill channel. It serves word-read requests `{id, offset}` delivered by the upstream fixed-priority request arbiter. It returns each requested word tagged with the requester id over a registered response channel, so the arbiter's winner is answered one cycle after acceptance.

## Interface

Clock and reset: one clock; reset is asynchronous and active-low. Ports are `clock` and `reset_n`.

Parameters:
- `DATA_W`, default 64: width of one line word.
- `WORDS`, default 4: words per line; power of two, ≥2.
- `ID_W`, default 2: requester id width.
- `OFF_W`, default $clog2(WORDS): offset width, derived.

Ports:
- `clock`, input, 1 bit: clock; all state updates on the rising edge.
- `reset_n`, input, 1 bit: asynchronous active-low reset.
- `io_refill_start`, input, 1 bit: single-cycle pulse that begins a new line fill.
- `io_refill_valid`, input, 1 bit: a refill beat is present.
- `io_refill_ready`, output, 1 bit: the block accepts the refill beat.
- `io_refill_data`, input, `DATA_W` bits: refill word; beats arrive in order, offset 0 first.
- `io_invalidate`, input, 1 bit: single-cycle pulse that discards the line.
- `io_req_valid`, input, 1 bit: a read request is present (driven by the arbiter `io_out_valid`).
- `io_req_ready`, output, 1 bit: the read request is accepted (drives the arbiter `io_out_ready`).
- `io_req_id`, input, `ID_W` bits: requester id.
- `io_req_offset`, input, `OFF_W` bits: word index within the line.
- `io_resp_valid`, output, 1 bit: a response is held.
- `io_resp_ready`, input, 1 bit: the consumer takes the response.
- `io_resp_id`, output, `ID_W` bits: id of the answered request.
- `io_resp_data`, output, `DATA_W` bits: the requested word.
- `io_state`, output, 2 bits: line state; EMPTY=0, FILLING=1, FULL=2.
- `io_word_valid`, output, `WORDS` bits: per-word "arrived" flags.

## Operation

- Storage: `WORDS` × `DATA_W` register array, plus `word_valid[WORDS]` and a beat counter of `OFF_W` bits.
- State machine:
  - EMPTY → FILLING on `io_refill_start`. This clears `word_valid` and sets the beat counter to 0.
  - FILLING → FULL when the beat with counter == `WORDS-1` is accepted.
  - FILLING or FULL → EMPTY on `io_invalidate`. This clears `word_valid` and the counter.
  - FILLING or FULL → FILLING on `io_refill_start`, which restarts the fill with the same clearing.
- Priority in any one cycle: `io_invalidate` > `io_refill_start` > refill beat > request.
- Refill ready: `io_refill_ready` = (state==FILLING) & !`io_invalidate` & !`io_refill_start`.
- Refill beat: an accepted beat writes `mem[counter]`, sets `word_valid[counter]` and increments the counter. The counter wraps to 0 on the last beat.
- Request ready: `io_req_ready` = (state!=EMPTY) & `word_valid[io_req_offset]` & (!`io_resp_valid` | `io_resp_ready`) & !`io_invalidate` & !`io_refill_start`.
  - This permits hit-under-fill on words that have already arrived.
  - There is no bypass: a word written this cycle is readable from the next cycle.
- Request accept: an accepted request loads `io_resp_id` ← `io_req_id`, `io_resp_data` ← `mem[io_req_offset]`, and sets `io_resp_valid`.
- Response hold: `io_resp_valid` clears on `io_resp_ready` unless a new request is accepted in the same cycle. In that case the register reloads and `io_resp_valid` stays 1.
- Captured responses survive `io_invalidate` and `io_refill_start`; they are delivered unchanged.
- Request valid/data are not required stable while `io_req_ready`=0. The arbiter may re-arbitrate.

## Timing

- Reset (asynchronous assert, synchronous release): state=EMPTY, `word_valid`=0, counter=0, `io_resp_valid`=0, `io_resp_id`=0, `io_resp_data`=0.
  - Consequently `io_refill_ready`=0 and `io_req_ready`=0. Array contents are don't-care.
- Latency: request accepted in cycle N gives `io_resp_valid`=1 in cycle N+1. Sustained throughput is 1 response/cycle while `io_resp_ready`=1.
- Beat-to-read latency: beat k accepted in cycle N means a request for offset k can be accepted in cycle N+1 at the earliest.
- Full line: starting from start pulse in cycle S with back-to-back beats, state=FULL in cycle S+1+`WORDS`.
- Backpressure: while `io_resp_valid` & !`io_resp_ready`, `io_resp_id` and `io_resp_data` are held stable and `io_req_ready`=0.
- Reset mid-fill or mid-response drops everything immediately. No partial response is emitted.
- `io_req_ready` depends combinationally on `io_req_offset`, `io_resp_ready`, `io_invalidate` and `io_refill_start` only. It never depends on `io_req_valid`.

## Test plan

- Reset, start pulse, then 4 beats 0xA0..0xA3 back-to-back.
  - Required: `io_state` goes 1 then 2 after the 4th beat.
  - Then req id=2, off=3 → next cycle `io_resp_valid`=1, id=2, data=0xA3.
- Hit-under-fill: after beats 0 and 1 only, req off=1 is accepted (data 0xA1). Req off=2 holds `io_req_ready`=0 until the cycle after beat 2 is accepted.
- Backpressure: hold `io_resp_ready`=0 for 3 cycles with a pending response (id=1, 0xA0).
  - Required: outputs stable, `io_req_ready`=0.
  - On release, a queued req off=2 is accepted in the same cycle and `io_resp_valid` stays 1 with data 0xA2.
- Invalidate during fill (after beat 1) together with a pending response.
  - Required: state=0, `word_valid`=0, `io_refill_ready`=0.
  - The held response is still delivered intact.
- Start and invalidate in the same cycle → EMPTY. Restart mid-fill, then 4 beats 0xB0..0xB3 → FULL; a read of off=0 returns 0xB0, not stale data.
- Four arbiter clients are valid simultaneously against a FULL line with `io_resp_ready`=1 → four responses on consecutive cycles, ids 0,1,2,3 in priority order.
